// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and frame constants.
package prog_loader_pkg;

  localparam int WORD_BYTES = 2;
  localparam int WORD_W     = 8 * WORD_BYTES;
  localparam int LEN_W      = 16;

  typedef enum logic [3:0] {
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CHECK,
    VERIFY,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs two stream bytes (MSB first) into one memory word; word_ready pulses
// for the single cycle after the low byte is captured.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data,
  input  logic              cap_hi,
  input  logic              cap_lo,
  output logic [7:0]        hi,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi         <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= cap_lo;
      if (cap_hi) hi <= data;
      if (cap_lo) word <= {hi, data};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed 16-bit word image into memory, then releases the CPU.
// Optional readback checksum pass enabled with `define PROG_LOADER_VERIFY_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 1024,
  parameter int ADD_SIZE = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [ADD_SIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                mem_we,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                cpu_run
);

  loader_state_t       state;
  logic [LEN_W-1:0]    len;
  logic [ADD_SIZE-1:0] idx;
  logic [WIDTH-1:0]    sum;

  logic                hs;
  logic                cap_hi;
  logic                cap_lo;
  logic [7:0]          asm_hi;
  logic [WORD_W-1:0]   asm_word;
  logic                asm_ready;
  logic [LEN_W-1:0]    len_next;
  logic                last_word;

  assign hs        = in_valid && in_ready;
  assign cap_hi    = hs && (state == LEN_HI || state == DATA_HI);
  assign cap_lo    = hs && (state == DATA_LO);
  assign len_next  = {asm_hi, in_data};
  assign last_word = (LEN_W'(idx) == len - 16'd1);

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .data       (in_data),
    .cap_hi     (cap_hi),
    .cap_lo     (cap_lo),
    .hi         (asm_hi),
    .word       (asm_word),
    .word_ready (asm_ready)
  );

  // The assembler's one-cycle pulse lands exactly on the WRITE state.
  assign mem_we    = asm_ready;
  assign mem_wdata = asm_word;

`ifdef PROG_LOADER_VERIFY_EN
  logic [WIDTH-1:0] rsum;
  logic [WIDTH-1:0] rsum_next;
  assign rsum_next = rsum + mem_rdata;
`else
  logic unused_rd;
  assign unused_rd = ^{mem_rdata, sum};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LEN_HI;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_run  <= 1'b0;
      mem_addr <= '0;
      len      <= '0;
      idx      <= '0;
      sum      <= '0;
`ifdef PROG_LOADER_VERIFY_EN
      rsum     <= '0;
`endif
    end else begin
      case (state)
        LEN_HI: begin
          in_ready <= 1'b1;
          if (hs) begin
            state <= LEN_LO;
            busy  <= 1'b1;
          end
        end
        LEN_LO: if (hs) begin
          len <= len_next;
          if (len_next == '0) begin
            state    <= DONE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_run  <= 1'b1;
          end else if (len_next > LEN_W'(DEPTH)) begin
            state    <= ERROR;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b1;
          end else begin
            state <= DATA_HI;
          end
        end
        DATA_HI: if (hs) state <= DATA_LO;
        DATA_LO: if (hs) begin
          state    <= WRITE;
          in_ready <= 1'b0;
          mem_addr <= idx;
        end
        WRITE: begin
          sum <= sum + asm_word;
          // idx stops at N-1 so N==DEPTH never wraps the address.
          if (last_word) begin
            state <= CHECK;
          end else begin
            state    <= DATA_HI;
            in_ready <= 1'b1;
            idx      <= idx + 1'b1;
          end
        end
        CHECK: begin
`ifdef PROG_LOADER_VERIFY_EN
          state    <= VERIFY;
          mem_addr <= '0;
          idx      <= '0;
          rsum     <= '0;
`else
          state   <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          cpu_run <= 1'b1;
`endif
        end
`ifdef PROG_LOADER_VERIFY_EN
        VERIFY: begin
          rsum <= rsum_next;
          if (last_word) begin
            busy <= 1'b0;
            if (rsum_next == sum) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end else begin
            idx      <= idx + 1'b1;
            mem_addr <= idx + 1'b1;
          end
        end
`endif
        DONE, ERROR: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: cycle table for a gap-free frame plus
// hand-written sequences for empty/oversize headers, stalls, reset and full depth.
module tb_prog_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_we;
  logic [15:0]   mem_rdata;
  logic          busy, done, error, cpu_run;

  always #5 clk = ~clk;

  prog_loader #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .error(error), .cpu_run(cpu_run)
  );

  // memory model with optional read corruption at address 1
  logic [15:0] mem [DEPTH];
  logic        corrupt = 1'b0;
  assign mem_rdata = (corrupt && mem_addr == 1) ? 16'h0003 : mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  logic [25:0] wlog [$];
  always @(negedge clk) if (mem_we) wlog.push_back({mem_addr, mem_wdata});

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wd;
    logic        bsy;
    logic        dn;
  } vec_t;
  vec_t tbl [$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic rdy, logic we, logic [9:0] addr,
                              logic [15:0] wd, logic bsy, logic dn);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.addr = addr; r.wd = wd; r.bsy = bsy; r.dn = dn;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Presents one byte after `gap` idle cycles; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0; in_data = 8'h5A;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = b;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 64) begin @(negedge clk); t++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL byte_timeout: got in_ready=0 expected 1 within 64 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_final(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!(done || error) && t < 5000) begin @(negedge clk); t++; end
    if (!(done || error)) begin
      total++; bad++;
      $display("FAIL %s_timeout: got done=0 error=0 expected a terminal state", name);
    end
  endtask

  initial begin
    int nbad;
    // gap-free N=3 frame, one row per cycle starting right after reset release
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 8'h00, 1, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 8'h03, 1, 0, 0, 16'h0000, 1, 0));
    tbl.push_back(mk(1, 8'h60, 1, 0, 0, 16'h0000, 1, 0));
    tbl.push_back(mk(1, 8'h00, 1, 0, 0, 16'h0000, 1, 0));
    tbl.push_back(mk(1, 8'hEE, 0, 1, 0, 16'h6000, 1, 0));
    tbl.push_back(mk(1, 8'h70, 1, 0, 0, 16'h6000, 1, 0));
    tbl.push_back(mk(1, 8'h01, 1, 0, 0, 16'h6000, 1, 0));
    tbl.push_back(mk(1, 8'hEE, 0, 1, 1, 16'h7001, 1, 0));
    tbl.push_back(mk(1, 8'h60, 1, 0, 1, 16'h7001, 1, 0));
    tbl.push_back(mk(1, 8'h17, 1, 0, 1, 16'h7001, 1, 0));
    tbl.push_back(mk(1, 8'hEE, 0, 1, 2, 16'h6017, 1, 0));
    tbl.push_back(mk(1, 8'hEE, 0, 0, 2, 16'h6017, 1, 0));
`ifdef PROG_LOADER_VERIFY_EN
    tbl.push_back(mk(1, 8'h55, 0, 0, 0, 16'h6017, 1, 0));
    tbl.push_back(mk(1, 8'h55, 0, 0, 1, 16'h6017, 1, 0));
    tbl.push_back(mk(1, 8'h55, 0, 0, 2, 16'h6017, 1, 0));
    tbl.push_back(mk(1, 8'h55, 0, 0, 2, 16'h6017, 0, 1));
    tbl.push_back(mk(1, 8'h55, 0, 0, 2, 16'h6017, 0, 1));
`else
    tbl.push_back(mk(1, 8'h55, 0, 0, 2, 16'h6017, 0, 1));
    tbl.push_back(mk(1, 8'h55, 0, 0, 2, 16'h6017, 0, 1));
`endif

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d;
      @(negedge clk);
      chk($sformatf("row%0d in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("row%0d mem_we", i), mem_we, tbl[i].we);
      chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata, tbl[i].wd);
      chk($sformatf("row%0d busy", i), busy, tbl[i].bsy);
      chk($sformatf("row%0d done", i), done, tbl[i].dn);
      chk($sformatf("row%0d cpu_run", i), cpu_run, tbl[i].dn);
      chk($sformatf("row%0d error", i), error, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // empty image: done straight after the length, no writes
    do_reset(); wlog.delete();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    @(negedge clk);
    chk("empty done", done, 1'b1);
    chk("empty cpu_run", cpu_run, 1'b1);
    chk("empty error", error, 1'b0);
    chk("empty busy", busy, 1'b0);
    chk("empty in_ready", in_ready, 1'b0);
    chk("empty writes", wlog.size(), 0);

    // oversize image: 1025 words rejected, stream refused afterwards
    do_reset(); wlog.delete();
    send_byte(8'h04, 0); send_byte(8'h01, 0);
    @(negedge clk);
    chk("over error", error, 1'b1);
    chk("over done", done, 1'b0);
    chk("over cpu_run", cpu_run, 1'b0);
    in_valid = 1'b1; in_data = 8'h12;
    nbad = 0;
    repeat (6) begin @(negedge clk); if (in_ready !== 1'b0) nbad++; end
    in_valid = 1'b0;
    chk("over in_ready_cycles", nbad, 0);
    chk("over writes", wlog.size(), 0);

    // stalled stream: valid high one cycle in three
    do_reset(); wlog.delete();
    send_byte(8'h00, 2); send_byte(8'h02, 2);
    send_byte(8'h12, 2); send_byte(8'h34, 2);
    send_byte(8'hBE, 2); send_byte(8'hEF, 2);
    wait_final("gap");
    chk("gap count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("gap w0", wlog[0], {10'd0, 16'h1234});
      chk("gap w1", wlog[1], {10'd1, 16'hBEEF});
    end
    chk("gap done", done, 1'b1);
    chk("gap error", error, 1'b0);

    // reset between DATA_HI and DATA_LO of word 1, then a fresh frame
    do_reset(); wlog.delete();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst outputs", {in_ready, mem_we, busy, done, error, cpu_run}, 6'b0);
    chk("rst mem_addr", mem_addr, 10'd0);
    chk("rst mem_wdata", mem_wdata, 16'h0000);
    chk("rst prior writes", wlog.size(), 1);
    wlog.delete();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hAB, 0); send_byte(8'hCD, 0);
    wait_final("rst");
    chk("rst count", wlog.size(), 1);
    if (wlog.size() == 1) chk("rst w0", wlog[0], {10'd0, 16'hABCD});
    chk("rst done", done, 1'b1);

    // full depth: 1024 words of value = address, last write at 1023
    do_reset(); wlog.delete();
    send_byte(8'h04, 0); send_byte(8'h00, 0);
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'(i >> 8), 0);
      send_byte(8'(i & 8'hFF), 0);
    end
    wait_final("full");
    chk("full count", wlog.size(), DEPTH);
    nbad = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i] !== {10'(i), 16'(i)}) nbad++;
    chk("full content", nbad, 0);
    chk("full done", done, 1'b1);
    chk("full error", error, 1'b0);

`ifdef PROG_LOADER_VERIFY_EN
    // readback pass: good memory finishes after 2 verify cycles, corrupted fails
    do_reset(); wlog.delete(); corrupt = 1'b0;
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    repeat (4) @(negedge clk);
    chk("vfy done_early", done, 1'b0);
    @(negedge clk);
    chk("vfy done", done, 1'b1);
    chk("vfy error", error, 1'b0);
    do_reset(); corrupt = 1'b1;
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    wait_final("vfy_bad");
    chk("vfy_bad error", error, 1'b1);
    chk("vfy_bad cpu_run", cpu_run, 1'b0);
    corrupt = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
